// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter. Four execution units (alu=0, mul=1, div=2, ls=3)
// request the broadcast bus. At most one unit is granted per rising edge.
// The granted unit's data and label are registered onto the bus, and the
// unit receives a one-cycle accept pulse.
//
// Parameters
//   DATA_W  : broadcast data width
//   LABEL_W : reservation-station label width (label 0 = "no producer")
//   RR_EN   : 1 = round-robin arbitration, 0 = fixed priority (unit 0 highest)
//
// Ports
//   clk          : clock, rising edge
//   RST          : synchronous active-high reset
//   require[3:0] : per-unit request (bit 3..0 = ls, div, mul, alu)
//   data0..3     : unit results, stable while the matching require is high
//   label0..3    : unit producer labels, stable while require is high
//   stall        : freeze arbitration; no grant while high
//   requireAC    : registered one-hot accept pulse to the granted unit
//   BCEN         : registered broadcast valid
//   BCdata       : registered broadcast data
//   BClabel      : registered broadcast label
//   err_label0   : sticky, a unit was granted while presenting label 0
//   bc_count     : number of broadcasts issued, wraps at 16 bits
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4,
  parameter int RR_EN   = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [3:0]         require,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic [LABEL_W-1:0] label0,
  input  logic [LABEL_W-1:0] label1,
  input  logic [LABEL_W-1:0] label2,
  input  logic [LABEL_W-1:0] label3,
  input  logic               stall,
  output logic [3:0]         requireAC,
  output logic               BCEN,
  output logic [DATA_W-1:0]  BCdata,
  output logic [LABEL_W-1:0] BClabel,
  output logic               err_label0,
  output logic [15:0]        bc_count
);

  // Index of the most recent grant; round-robin search starts one past it.
  logic [1:0] ptr;

  logic [3:0]         eligible_p0;
  logic               grant_vld_p0;
  logic [1:0]         grant_idx_p0;
  logic [DATA_W-1:0]  sel_data_p0;
  logic [LABEL_W-1:0] sel_label_p0;
  logic               sel_label_zero_p0;

  // Round-robin pick: {found, index}. Candidates are visited in ascending
  // order starting at last+1; the 2-bit add gives the wrap-around for free.
  function automatic logic [2:0] pick_rr(input logic [3:0] elig,
                                         input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + i[1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Fixed-priority pick: lowest eligible index wins.
  function automatic logic [2:0] pick_fixed(input logic [3:0] elig);
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        idx   = i[1:0];
      end
    end
    return {found, idx};
  endfunction

  // ---- stage p0: eligibility, arbitration and operand select ----
  // The unit accepted on the previous edge is masked so a requester that has
  // not yet dropped require cannot be granted twice in a row.
  assign eligible_p0 = stall ? 4'b0000 : (require & ~requireAC);

  always_comb begin
    logic [2:0] pick;
    if (RR_EN != 0) pick = pick_rr(eligible_p0, ptr);
    else            pick = pick_fixed(eligible_p0);
    grant_vld_p0 = pick[2];
    grant_idx_p0 = pick[1:0];
  end

  always_comb begin
    sel_data_p0  = '0;
    sel_label_p0 = '0;
    case (grant_idx_p0)
      2'd0: begin sel_data_p0 = data0; sel_label_p0 = label0; end
      2'd1: begin sel_data_p0 = data1; sel_label_p0 = label1; end
      2'd2: begin sel_data_p0 = data2; sel_label_p0 = label2; end
      default: begin sel_data_p0 = data3; sel_label_p0 = label3; end
    endcase
  end

  assign sel_label_zero_p0 = (sel_label_p0 == '0);

  // ---- stage p1: registered bus outputs ----
  always_ff @(posedge clk) begin
    if (RST) begin
      requireAC  <= 4'b0000;
      BCEN       <= 1'b0;
      BCdata     <= '0;
      BClabel    <= '0;
      err_label0 <= 1'b0;
      bc_count   <= 16'd0;
      ptr        <= 2'd3;
    end else if (grant_vld_p0) begin
      requireAC <= 4'b0001 << grant_idx_p0;
      ptr       <= grant_idx_p0;
      if (sel_label_zero_p0) begin
        // Granted without a producer label: consume the request but keep
        // the bus quiet and flag the protocol error.
        BCEN       <= 1'b0;
        BCdata     <= '0;
        BClabel    <= '0;
        err_label0 <= 1'b1;
      end else begin
        BCEN     <= 1'b1;
        BCdata   <= sel_data_p0;
        BClabel  <= sel_label_p0;
        bc_count <= bc_count + 16'd1;
      end
    end else begin
      requireAC <= 4'b0000;
      BCEN      <= 1'b0;
      BCdata    <= '0;
      BClabel   <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic          stall;
  logic [3:0]    require;
  logic [DW-1:0] data [4];
  logic [LW-1:0] label [4];

  // Mode 0: round-robin DUT, mode 1: fixed-priority DUT
  logic [3:0]    ac_rr, ac_fp;
  logic          en_rr, en_fp;
  logic [DW-1:0] dat_rr, dat_fp;
  logic [LW-1:0] lab_rr, lab_fp;
  logic          err_rr, err_fp;
  logic [15:0]   cnt_rr, cnt_fp;

  cdb_arbiter #(.DATA_W(DW), .LABEL_W(LW), .RR_EN(1)) dut (
    .clk(clk), .RST(RST), .require(require),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .label0(label[0]), .label1(label[1]), .label2(label[2]), .label3(label[3]),
    .stall(stall), .requireAC(ac_rr), .BCEN(en_rr), .BCdata(dat_rr),
    .BClabel(lab_rr), .err_label0(err_rr), .bc_count(cnt_rr));

  cdb_arbiter #(.DATA_W(DW), .LABEL_W(LW), .RR_EN(0)) dut_fp (
    .clk(clk), .RST(RST), .require(require),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .label0(label[0]), .label1(label[1]), .label2(label[2]), .label3(label[3]),
    .stall(stall), .requireAC(ac_fp), .BCEN(en_fp), .BCdata(dat_fp),
    .BClabel(lab_fp), .err_label0(err_fp), .bc_count(cnt_fp));

  // Behavioural model state, one entry per mode
  logic [3:0]    m_ac    [2];
  logic          m_en    [2];
  logic [DW-1:0] m_data  [2];
  logic [LW-1:0] m_label [2];
  logic          m_err   [2];
  int            m_cnt   [2];
  int            m_last  [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next outputs from the rules: mask last accept, pick winner, broadcast
  // unless the label is zero.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int k;
      logic [3:0] el;
      if (RST) begin
        m_ac[m] = 4'b0; m_en[m] = 1'b0; m_data[m] = '0; m_label[m] = '0;
        m_err[m] = 1'b0; m_cnt[m] = 0; m_last[m] = 3;
      end else begin
        k  = -1;
        el = stall ? 4'b0 : (require & ~m_ac[m]);
        if (m == 0) begin
          for (int i = 1; i <= 4; i++)
            if (k < 0 && el[(m_last[m] + i) % 4]) k = (m_last[m] + i) % 4;
        end else begin
          for (int c = 0; c < 4; c++)
            if (k < 0 && el[c]) k = c;
        end
        if (k < 0) begin
          m_ac[m] = 4'b0; m_en[m] = 1'b0; m_data[m] = '0; m_label[m] = '0;
        end else begin
          m_last[m] = k;
          m_ac[m]   = 4'(1 << k);
          if (label[k] == 0) begin
            m_en[m] = 1'b0; m_data[m] = '0; m_label[m] = '0; m_err[m] = 1'b1;
          end else begin
            m_en[m] = 1'b1; m_data[m] = data[k]; m_label[m] = label[k];
            m_cnt[m] = (m_cnt[m] + 1) % 65536;
          end
        end
      end
    end
  endtask

  // One clock: advance model, let DUT sample, compare away from the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rr.requireAC", 64'(ac_rr),  64'(m_ac[0]));
    chk("rr.BCEN",      64'(en_rr),  64'(m_en[0]));
    chk("rr.BCdata",    64'(dat_rr), 64'(m_data[0]));
    chk("rr.BClabel",   64'(lab_rr), 64'(m_label[0]));
    chk("rr.err",       64'(err_rr), 64'(m_err[0]));
    chk("rr.bc_count",  64'(cnt_rr), 64'(m_cnt[0]));
    chk("fp.requireAC", 64'(ac_fp),  64'(m_ac[1]));
    chk("fp.BCEN",      64'(en_fp),  64'(m_en[1]));
    chk("fp.BCdata",    64'(dat_fp), 64'(m_data[1]));
    chk("fp.BClabel",   64'(lab_fp), 64'(m_label[1]));
    chk("fp.err",       64'(err_fp), 64'(m_err[1]));
    chk("fp.bc_count",  64'(cnt_fp), 64'(m_cnt[1]));
  endtask

  task automatic do_reset();
    RST = 1'b1; require = 4'b0; stall = 1'b0;
    step();
    RST = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_order [5];
    logic [3:0] prev;
    RST = 1'b1; stall = 1'b0; require = 4'b0;
    for (int i = 0; i < 4; i++) begin data[i] = '0; label[i] = '0; end
    for (int m = 0; m < 2; m++) begin
      m_ac[m] = 0; m_en[m] = 0; m_data[m] = 0; m_label[m] = 0;
      m_err[m] = 0; m_cnt[m] = 0; m_last[m] = 3;
    end
    @(negedge clk);

    // Reset state, literal
    do_reset();
    chk("lit.reset.ac",  64'(ac_rr), 64'h0);
    chk("lit.reset.en",  64'(en_rr), 64'h0);
    chk("lit.reset.cnt", 64'(cnt_rr), 64'h0);
    chk("lit.reset.err", 64'(err_rr), 64'h0);

    // Single request from alu
    require = 4'b0001; label[0] = 4'd5; data[0] = 32'h1234;
    step();
    chk("lit.single.en",    64'(en_rr),  64'h1);
    chk("lit.single.label", 64'(lab_rr), 64'h5);
    chk("lit.single.data",  64'(dat_rr), 64'h1234);
    chk("lit.single.ac",    64'(ac_rr),  64'h1);
    chk("lit.single.cnt",   64'(cnt_rr), 64'h1);

    // Round-robin order with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin label[i] = 4'(i + 1); data[i] = 32'hA000 + i; end
    require = 4'b1111;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    prev = 4'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lit.rr.order", 64'(ac_rr), 64'(exp_order[i]));
      chk("lit.rr.norepeat", 64'(ac_rr == prev), 64'h0);
      prev = ac_rr;
    end

    // Fixed priority alternation for 1010
    do_reset();
    require = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lit.fp.alt", 64'(ac_fp), (i % 2 == 0) ? 64'h2 : 64'h8);
    end

    // Zero label grant
    do_reset();
    require = 4'b0100; label[2] = 4'd0;
    step();
    chk("lit.zero.ac",  64'(ac_rr),  64'h4);
    chk("lit.zero.en",  64'(en_rr),  64'h0);
    chk("lit.zero.err", 64'(err_rr), 64'h1);
    chk("lit.zero.cnt", 64'(cnt_rr), 64'h0);
    label[2] = 4'd3;

    // Stall keeps ptr; first grant after stall follows pre-stall pointer
    do_reset();
    require = 4'b0011;
    step();
    chk("lit.stall.pre", 64'(ac_rr), 64'h1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit.stall.ac", 64'(ac_rr), 64'h0);
      chk("lit.stall.en", 64'(en_rr), 64'h0);
    end
    stall = 1'b0;
    step();
    chk("lit.stall.post.rr", 64'(ac_rr), 64'h2);
    chk("lit.stall.post.fp", 64'(ac_fp), 64'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      require = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        data[i]  = $urandom;
        label[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      step();
    end
    RST = 1'b0; stall = 1'b0;

    // Counter wrap
    do_reset();
    require = 4'b0011; label[0] = 4'd1; label[1] = 4'd2;
    for (int i = 0; i < 65535; i++) step();
    chk("lit.wrap.full", 64'(cnt_rr), 64'hFFFF);
    step();
    chk("lit.wrap.zero", 64'(cnt_rr), 64'h0);

    // Reset during a grant cycle discards the pending grant
    require = 4'b0011;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("lit.rstgrant.ac",  64'(ac_rr),  64'h0);
    chk("lit.rstgrant.en",  64'(en_rr),  64'h0);
    chk("lit.rstgrant.dat", 64'(dat_rr), 64'h0);
    chk("lit.rstgrant.cnt", 64'(cnt_rr), 64'h0);
    step();
    chk("lit.rearb.ac", 64'(ac_rr), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, broadcast data width.
REQ-002 SHALL have parameter LABEL_W, default 4, reservation-station label width; label 0 means "no producer".
REQ-003 SHALL have parameter RR_EN, default 1; 1 selects round-robin, 0 selects fixed priority (index 0 highest).
REQ-004 SHALL have ports as listed, with clock and reset first. The design uses one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 require  input  4  per-unit broadcast request; bit 3..0 = ls, div, mul, alu.
REQ-008 data0..data3  input  DATA_W each  result from unit 0..3, held stable while its require is high.
REQ-009 label0..label3  input  LABEL_W each  producer label from unit 0..3, held stable while its require is high.
REQ-010 stall  input  1  freezes arbitration when high; no grant is issued.
REQ-011 requireAC  output  4  one-hot registered accept pulse to the granted unit.
REQ-012 BCEN  output  1  registered broadcast valid.
REQ-013 BCdata  output  DATA_W  registered broadcast data.
REQ-014 BClabel  output  LABEL_W  registered broadcast label.
REQ-015 err_label0  output  1  sticky flag: a unit was granted while presenting label 0.
REQ-016 bc_count  output  16  count of broadcasts issued; wraps.

Function
REQ-017 Eligible set at each edge = require AND NOT requireAC (the unit accepted this cycle is masked), gated by NOT stall.
REQ-018 Arbitration SHALL grant at most one unit per edge; the outputs are registered, so latency from require sampled to BCEN/requireAC is 1 cycle.
REQ-019 Round-robin: a pointer ptr[1:0] holds the last granted index; the search starts at ptr+1 mod 4 and proceeds ascending with wrap-around. ptr SHALL update only on a grant.
REQ-020 Fixed priority (RR_EN=0): the lowest eligible index wins; ptr is unused.
REQ-021 On a grant of unit k: requireAC <= one-hot(k), BCdata <= data_k, BClabel <= label_k, BCEN <= (label_k != 0), bc_count increments if BCEN is set.
REQ-022 Granted with label_k == 0: requireAC still pulses, BCEN <= 0, BCdata/BClabel <= 0, err_label0 <= 1.
REQ-023 No grant (none eligible, or stall high): requireAC <= 0, BCEN <= 0, BCdata <= 0, BClabel <= 0.
REQ-024 requireAC SHALL be high for exactly 1 cycle per grant; the requester drops require on the cycle after seeing it, and the REQ-017 mask prevents a double grant.
REQ-025 Back-to-back: a unit re-asserting require after its accept cycle SHALL be eligible again from the next edge.
REQ-026 Starvation bound (RR_EN=1): a continuously requesting unit SHALL be granted within 4 edges of unstalled arbitration.
REQ-027 stall SHALL NOT alter ptr, err_label0 or bc_count.
REQ-028 bc_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-029 With RST high at an edge: requireAC=0, BCEN=0, BCdata=0, BClabel=0, err_label0=0, bc_count=0, ptr=3 (so the first round-robin search starts at unit 0).
REQ-030 RST SHALL take priority over stall and require. A grant pending when RST is asserted mid-operation is discarded, not replayed; units holding require are re-arbitrated after reset.

Verification
REQ-031 Reset, then require=4'b0001, label0=5, data0=32'h1234 -> next cycle BCEN=1, BClabel=5, BCdata=32'h1234, requireAC=4'b0001, bc_count=1.
REQ-032 RR_EN=1, require=4'b1111 held continuously with labels 1..4 -> grant order alu, mul, div, ls, alu on consecutive cycles; requireAC never repeats an index twice in a row.
REQ-033 RR_EN=0, require=4'b1010 held -> unit 1 granted every other cycle; unit 3 is granted only on the cycles where unit 1 is masked.
REQ-034 require=4'b0100 with label2=0 -> requireAC=4'b0100, BCEN=0, err_label0=1, bc_count unchanged.
REQ-035 stall=1 for 3 cycles with require=4'b0011 -> no requireAC and BCEN=0 throughout; the first grant after stall drops follows the pre-stall ptr.
REQ-036 Preload bc_count=16'hFFFF via 65535 broadcasts, then one more broadcast -> bc_count=0; RST asserted during a grant cycle -> all outputs 0 on the next cycle.
